// File: rtl/aes_ctr_sarmal.sv
// aes_ctr_sarmal -- CTR-mode wrapper in front of an in-order, fixed-latency ECB
// aes_engine. It holds the counter, parks each plaintext block in a FIFO while
// its keystream is computed, XORs the returned keystream with it, and queues
// the ciphertext behind a backpressured output.
//
// Build option: define AES_CTR_TASMA_KILIT_EN to block new blocks after the
// counter wraps, until iv_yukle reloads the counter. This prevents keystream
// reuse. Without it the counter wraps silently and only tasma reports it.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   anahtar            key, forwarded unregistered to m_anahtar
//   iv, iv_yukle       counter load value / load strobe
//   blok, g_gecerli    plaintext block / valid; hazir = accept ready
//   sifre, c_gecerli   ciphertext head (0 when empty) / valid; c_hazir = ready
//   tasma, hata        sticky counter-wrap / stray engine-return flags
//   m_anahtar, m_blok, m_gecerli, m_hazir      engine request side
//   m_sifre, m_c_gecerli                       engine keystream return
module aes_ctr_sarmal #(
   parameter int BLOK_W   = 128,
   parameter int SAYAC_W  = 32,
   parameter int DERINLIK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BLOK_W-1:0] anahtar,
   input  logic [BLOK_W-1:0] iv,
   input  logic              iv_yukle,
   input  logic [BLOK_W-1:0] blok,
   input  logic              g_gecerli,
   output logic              hazir,
   output logic [BLOK_W-1:0] sifre,
   output logic              c_gecerli,
   input  logic              c_hazir,
   output logic              tasma,
   output logic              hata,
   output logic [BLOK_W-1:0] m_anahtar,
   output logic [BLOK_W-1:0] m_blok,
   output logic              m_gecerli,
   input  logic              m_hazir,
   input  logic [BLOK_W-1:0] m_sifre,
   input  logic              m_c_gecerli
);

   localparam int PTR_W = $clog2(DERINLIK);
   localparam int CNT_W = $clog2(DERINLIK) + 1;
   localparam logic [CNT_W:0] DERIN_L = (CNT_W+1)'(DERINLIK);

   logic [BLOK_W-1:0] sayac_q, sayac_d;
   logic              tasma_q, tasma_d;
   logic              hata_q, hata_d;

   logic [BLOK_W-1:0] pt_mem_q [DERINLIK];
   logic [PTR_W-1:0]  pt_wr_q, pt_wr_d, pt_rd_q, pt_rd_d;
   logic [CNT_W-1:0]  pt_cnt_q, pt_cnt_d;

   logic [BLOK_W-1:0] out_mem_q [DERINLIK];
   logic [PTR_W-1:0]  out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

   logic [CNT_W:0]    kredi;
   logic              kilit, kabul, donus, pt_bos, out_pop;

`ifdef AES_CTR_TASMA_KILIT_EN
   assign kilit = tasma_q;
`else
   assign kilit = 1'b0;
`endif

   // Credit covers both queues, so a keystream return always finds room
   // in the output FIFO even when downstream is stalled.
   assign kredi = DERIN_L - ({1'b0, pt_cnt_q} + {1'b0, out_cnt_q});

   assign hazir     = ~rst & m_hazir & (kredi != '0) & ~iv_yukle & ~kilit;
   assign kabul     = g_gecerli & hazir;
   assign m_gecerli = kabul;
   assign m_blok    = sayac_q;
   assign m_anahtar = anahtar;

   assign pt_bos    = (pt_cnt_q == '0);
   // A return with nothing parked has no plaintext to pair with: drop it.
   assign donus     = m_c_gecerli & ~pt_bos;

   assign c_gecerli = (out_cnt_q != '0);
   assign sifre     = c_gecerli ? out_mem_q[out_rd_q] : '0;
   assign out_pop   = c_gecerli & c_hazir;

   assign tasma     = tasma_q;
   assign hata      = hata_q;

   always_comb begin
      sayac_d = sayac_q;
      tasma_d = tasma_q;
      hata_d  = hata_q;
      // iv_yukle and an accept never coincide: hazir is low during a load.
      if (iv_yukle) begin
         sayac_d = iv;
         tasma_d = 1'b0;
      end else if (kabul) begin
         sayac_d[SAYAC_W-1:0] = sayac_q[SAYAC_W-1:0] + 1'b1;
         if (&sayac_q[SAYAC_W-1:0]) tasma_d = 1'b1;
      end
      if (m_c_gecerli && pt_bos) hata_d = 1'b1;
   end

   always_comb begin
      pt_wr_d   = pt_wr_q;
      pt_rd_d   = pt_rd_q;
      pt_cnt_d  = pt_cnt_q;
      out_wr_d  = out_wr_q;
      out_rd_d  = out_rd_q;
      out_cnt_d = out_cnt_q;
      if (kabul)   pt_wr_d  = pt_wr_q + 1'b1;
      if (donus)   pt_rd_d  = pt_rd_q + 1'b1;
      if (donus)   out_wr_d = out_wr_q + 1'b1;
      if (out_pop) out_rd_d = out_rd_q + 1'b1;
      case ({kabul, donus})
         2'b10:   pt_cnt_d = pt_cnt_q + 1'b1;
         2'b01:   pt_cnt_d = pt_cnt_q - 1'b1;
         default: ;
      endcase
      case ({donus, out_pop})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sayac_q   <= '0;
         tasma_q   <= 1'b0;
         hata_q    <= 1'b0;
         pt_wr_q   <= '0;
         pt_rd_q   <= '0;
         pt_cnt_q  <= '0;
         out_wr_q  <= '0;
         out_rd_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         sayac_q   <= sayac_d;
         tasma_q   <= tasma_d;
         hata_q    <= hata_d;
         pt_wr_q   <= pt_wr_d;
         pt_rd_q   <= pt_rd_d;
         pt_cnt_q  <= pt_cnt_d;
         out_wr_q  <= out_wr_d;
         out_rd_q  <= out_rd_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Storage carries no reset; occupancy counters decide what is valid.
   always_ff @(posedge clk) begin
      if (kabul) pt_mem_q[pt_wr_q] <= blok;
      if (donus) out_mem_q[out_wr_q] <= m_sifre ^ pt_mem_q[pt_rd_q];
   end

endmodule
